arp_encode: RTL and testbench

- Byte-serial ARP packet generator; the transmit-side counterpart of the ARP receive decoder.
- Latches operation code plus sender/target hardware and protocol addresses on a start pulse.
- Streams the 28-byte ARP payload, followed by optional zero padding, to the Ethernet TX framer over a valid/ready byte stream.
- Field packing matches the receive decoder: the first wire byte of every multi-byte address field is field[7:0]. Decoded addresses can therefore be looped back (swapped) into a reply without byte reordering.

---
 rtl/arp_encode.sv | 204 ++++++++++++++++++++
 tb/tb_arp_encode.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arp_encode.sv
// arp_encode: byte-serial ARP packet generator for the Ethernet TX framer.
// On start (idle only) the operation code and the four address fields are
// latched. The 28-byte ARP payload follows, then PAD_LEN bytes of 0x00.
// Multi-byte address fields go out low byte first, field[7:0] leading, to
// match the receive decoder. The operation code goes out MSB byte first.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             single-cycle request, honoured only while busy=0
//   op/sha/spa/tha/tpa ARP fields, sampled on the accepted start cycle
//   dout, dout_valid  byte stream to the framer
//   dout_ready        downstream handshake; a byte moves when valid&ready
//   dout_last         marks the final byte of the packet
//   busy              packet in progress (includes the done cycle)
//   done              one-cycle pulse after the last byte is accepted
//
// state  | meaning
// IDLE   | waiting for start, busy=0
// SEND   | presenting ARP byte cnt (0..27)
// PAD    | presenting 0x00 pad bytes, pad_cnt counts down to 0
// DONE   | one-cycle done pulse, busy still high

module arp_encode #(
    parameter int PAD_LEN = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] op,
    input  logic [47:0] sha,
    input  logic [31:0] spa,
    input  logic [47:0] tha,
    input  logic [31:0] tpa,
    output logic [7:0]  dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        dout_last,
    output logic        busy,
    output logic        done
);

    localparam int            PW       = (PAD_LEN > 1) ? $clog2(PAD_LEN) : 1;
    localparam logic [PW-1:0] PAD_LOAD = PW'((PAD_LEN > 0) ? PAD_LEN - 1 : 0);
    localparam logic [4:0]    LAST_ARP = 5'd27;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_PAD, S_DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [4:0]    cnt;
    logic [PW-1:0] pad_cnt;
    logic [15:0]   op_q;
    logic [47:0]   sha_q;
    logic [31:0]   spa_q;
    logic [47:0]   tha_q;
    logic [31:0]   tpa_q;
    logic [7:0]    arp_byte;
    logic          accept;

    assign accept = dout_valid && dout_ready;

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // byte index counts up (it addresses the payload), pad counter counts
    // down to a terminal zero
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            pad_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt     <= '0;
                        pad_cnt <= PAD_LOAD;
                    end
                end
                S_SEND: begin
                    if (accept && cnt != LAST_ARP) begin
                        cnt <= cnt + 5'd1;
                    end
                end
                S_PAD: begin
                    if (accept && pad_cnt != '0) begin
                        pad_cnt <= pad_cnt - PW'(1);
                    end
                end
                S_DONE: begin
                    cnt <= '0;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    // field capture; only an idle start outside reset may overwrite them
    always_ff @(posedge clk) begin
        if (!rst && state == S_IDLE && start) begin
            op_q  <= op;
            sha_q <= sha;
            spa_q <= spa;
            tha_q <= tha;
            tpa_q <= tpa;
        end
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_SEND;
            end
            S_SEND: begin
                if (accept && cnt == LAST_ARP) begin
                    state_nxt = (PAD_LEN > 0) ? S_PAD : S_DONE;
                end
            end
            S_PAD: begin
                if (accept && pad_cnt == '0) state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // payload byte selection
    always_comb begin
        arp_byte = 8'h00;
        case (cnt)
            5'd1:    arp_byte = 8'h01;
            5'd2:    arp_byte = 8'h08;
            5'd4:    arp_byte = 8'h06;
            5'd5:    arp_byte = 8'h04;
            5'd6:    arp_byte = op_q[15:8];
            5'd7:    arp_byte = op_q[7:0];
            5'd8:    arp_byte = sha_q[7:0];
            5'd9:    arp_byte = sha_q[15:8];
            5'd10:   arp_byte = sha_q[23:16];
            5'd11:   arp_byte = sha_q[31:24];
            5'd12:   arp_byte = sha_q[39:32];
            5'd13:   arp_byte = sha_q[47:40];
            5'd14:   arp_byte = spa_q[7:0];
            5'd15:   arp_byte = spa_q[15:8];
            5'd16:   arp_byte = spa_q[23:16];
            5'd17:   arp_byte = spa_q[31:24];
            5'd18:   arp_byte = tha_q[7:0];
            5'd19:   arp_byte = tha_q[15:8];
            5'd20:   arp_byte = tha_q[23:16];
            5'd21:   arp_byte = tha_q[31:24];
            5'd22:   arp_byte = tha_q[39:32];
            5'd23:   arp_byte = tha_q[47:40];
            5'd24:   arp_byte = tpa_q[7:0];
            5'd25:   arp_byte = tpa_q[15:8];
            5'd26:   arp_byte = tpa_q[23:16];
            5'd27:   arp_byte = tpa_q[31:24];
            default: arp_byte = 8'h00;
        endcase
    end

    // outputs are pure functions of registered state, so they hold
    // unchanged under backpressure without extra output registers
    always_comb begin
        dout       = 8'h00;
        dout_valid = 1'b0;
        dout_last  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_SEND: begin
                dout_valid = 1'b1;
                dout       = arp_byte;
                dout_last  = (PAD_LEN == 0) && (cnt == LAST_ARP);
            end
            S_PAD: begin
                dout_valid = 1'b1;
                dout_last  = (pad_cnt == '0);
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_arp_encode.sv
// tb_arp_encode: directed bench for arp_encode. Two instances share the
// field inputs: u_pad (PAD_LEN=18) and u_nopad (PAD_LEN=0). Inputs are
// driven 1 time unit after the rising edge, outputs sampled on the
// falling edge.

module tb_arp_encode;

    typedef struct {
        string       name;
        bit          sel;
        logic [15:0] op;
        logic [47:0] sha;
        logic [31:0] spa;
        logic [47:0] tha;
        logic [31:0] tpa;
        bit          bp;
        bit          hand;
        int          exp_len;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start0, start1;
    logic [15:0] op;
    logic [47:0] sha, tha;
    logic [31:0] spa, tpa;
    logic        ready0, ready1;
    logic [7:0]  dout0, dout1;
    logic        valid0, valid1, last0, last1, busy0, busy1, done0, done1;

    int nvec = 0;
    int nerr = 0;

    logic [7:0] req_a [46];
    vec_t       vecs [5];

    logic [7:0] cap [$];
    int last_pos, n_last, n_done, done_cyc, last_acc_cyc, busy_after;
    int first_valid_cyc, bubbles, holdbad, extra_valid;

    arp_encode #(.PAD_LEN(18)) u_pad (
        .clk(clk), .rst(rst), .start(start0), .op(op), .sha(sha), .spa(spa),
        .tha(tha), .tpa(tpa), .dout(dout0), .dout_valid(valid0),
        .dout_ready(ready0), .dout_last(last0), .busy(busy0), .done(done0)
    );

    arp_encode #(.PAD_LEN(0)) u_nopad (
        .clk(clk), .rst(rst), .start(start1), .op(op), .sha(sha), .spa(spa),
        .tha(tha), .tpa(tpa), .dout(dout1), .dout_valid(valid1),
        .dout_ready(ready1), .dout_last(last1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_byte(input vec_t v, input int i);
        if (i == 1) return 8'h01;
        if (i == 2) return 8'h08;
        if (i == 4) return 8'h06;
        if (i == 5) return 8'h04;
        if (i == 6) return v.op[15:8];
        if (i == 7) return v.op[7:0];
        if (i >= 8 && i < 14) return v.sha[8*(i-8) +: 8];
        if (i >= 14 && i < 18) return v.spa[8*(i-14) +: 8];
        if (i >= 18 && i < 24) return v.tha[8*(i-18) +: 8];
        if (i >= 24 && i < 28) return v.tpa[8*(i-24) +: 8];
        return 8'h00;
    endfunction

    task automatic set_start(input bit sel, input logic val);
        if (sel) start1 = val;
        else start0 = val;
    endtask

    task automatic run_pkt(input bit sel, input logic [15:0] o_, input logic [47:0] sh,
                           input logic [31:0] sp, input logic [47:0] th, input logic [31:0] tp,
                           input bit bp, input int inj_at, input bit inj_done);
        bit         injected = 0;
        bit         pend = 0;
        bit         seen_first = 0;
        logic       prev_hold = 0;
        logic [7:0] prev_dout = 0;
        logic       prev_last = 0;
        logic       v, r, l, b, d;
        logic [7:0] o;
        cap.delete();
        last_pos = -1; n_last = 0; n_done = 0; done_cyc = -1; last_acc_cyc = -1;
        busy_after = -1; first_valid_cyc = -1; bubbles = 0; holdbad = 0; extra_valid = 0;
        @(posedge clk); #1;
        op = o_; sha = sh; spa = sp; tha = th; tpa = tp;
        set_start(sel, 1'b1);
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
        op = 16'($urandom); sha = {16'($urandom), $urandom}; spa = $urandom;
        tha = {16'($urandom), $urandom}; tpa = $urandom;
        for (int c = 0; c < 500; c++) begin
            r = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (sel) ready1 = r;
            else ready0 = r;
            if (inj_at >= 0 && !injected && cap.size() == inj_at) begin
                injected = 1;
                op = 16'h0002;
                set_start(sel, 1'b1);
            end
            if (pend) begin
                pend = 0;
                set_start(sel, 1'b1);
            end
            @(negedge clk);
            v = sel ? valid1 : valid0;
            l = sel ? last1 : last0;
            b = sel ? busy1 : busy0;
            d = sel ? done1 : done0;
            o = sel ? dout1 : dout0;
            if (prev_hold && (!v || o !== prev_dout || l !== prev_last)) holdbad++;
            prev_hold = v && !r;
            prev_dout = o;
            prev_last = l;
            if (v && first_valid_cyc < 0) first_valid_cyc = c;
            if (seen_first && last_acc_cyc < 0 && !v) bubbles++;
            if (v) seen_first = 1;
            if (done_cyc >= 0) begin
                if (v) extra_valid++;
                if (c == done_cyc + 1) busy_after = int'(b);
            end
            if (v && r) begin
                cap.push_back(o);
                if (l) begin
                    n_last++;
                    last_pos = cap.size() - 1;
                    last_acc_cyc = c;
                    if (inj_done) pend = 1;
                end
            end
            if (d) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
            end
            @(posedge clk); #1;
            start0 = 1'b0; start1 = 1'b0;
            if (done_cyc >= 0 && c >= done_cyc + 6) break;
        end
        ready0 = 1'b1; ready1 = 1'b1;
    endtask

    task automatic check_pkt(input vec_t v);
        int n;
        chk({v.name, "_len"}, 64'(cap.size()), 64'(v.exp_len));
        n = (cap.size() < v.exp_len) ? cap.size() : v.exp_len;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_byte%0d", v.name, i), 64'(cap[i]),
                64'(v.hand ? req_a[i] : model_byte(v, i)));
        end
        chk({v.name, "_last_cnt"}, 64'(n_last), 64'd1);
        chk({v.name, "_last_pos"}, 64'(last_pos), 64'(v.exp_len - 1));
        chk({v.name, "_done_cnt"}, 64'(n_done), 64'd1);
        chk({v.name, "_done_lat"}, 64'(done_cyc), 64'(last_acc_cyc + 1));
        chk({v.name, "_busy_after"}, 64'(busy_after), 64'd0);
        chk({v.name, "_first_lat"}, 64'(first_valid_cyc), 64'd0);
        chk({v.name, "_hold"}, 64'(holdbad), 64'd0);
        chk({v.name, "_post_valid"}, 64'(extra_valid), 64'd0);
        if (!v.bp) chk({v.name, "_bubbles"}, 64'(bubbles), 64'd0);
    endtask

    initial begin
        logic [7:0] hdr [28];
        int         ndone;
        logic [15:0] d_htype, d_ptype, d_op;
        logic [7:0]  d_hlen, d_plen;
        logic [47:0] d_sha, d_tha;
        logic [31:0] d_spa, d_tpa;
        logic        d_err;

        hdr = '{8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01,
                8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                8'hC0, 8'hA8, 8'h00, 8'h0A,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                8'hC0, 8'hA8, 8'h00, 8'h01};
        for (int i = 0; i < 46; i++) req_a[i] = (i < 28) ? hdr[i] : 8'h00;

        vecs[0] = '{"req_ready", 1'b0, 16'h0001, 48'h665544332211, 32'h0A00A8C0,
                    48'h0, 32'h0100A8C0, 1'b0, 1'b1, 46};
        vecs[1] = '{"req_bp", 1'b0, 16'h0001, 48'h665544332211, 32'h0A00A8C0,
                    48'h0, 32'h0100A8C0, 1'b1, 1'b1, 46};
        vecs[2] = '{"rep_ready", 1'b0, 16'h0002, 48'hA1B2C3D4E5F6, 32'h01020304,
                    48'h665544332211, 32'h0A00A8C0, 1'b0, 1'b0, 46};
        vecs[3] = '{"nopad_rep", 1'b1, 16'h0002, 48'hA1B2C3D4E5F6, 32'h0100A8C0,
                    48'h665544332211, 32'hDEADBEEF, 1'b0, 1'b0, 28};
        vecs[4] = '{"nopad_bp", 1'b1, 16'h0001, 48'h0123456789AB, 32'hC0A80001,
                    48'hFEDCBA987654, 32'h7F000001, 1'b1, 1'b0, 28};

        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; ready0 = 1'b1; ready1 = 1'b1;
        op = '0; sha = '0; spa = '0; tha = '0; tpa = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dout", 64'(dout0), 64'd0);
        chk("rst_valid", 64'(valid0), 64'd0);
        chk("rst_last", 64'(last0), 64'd0);
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_done", 64'(done0), 64'd0);
        chk("rst_busy_nopad", 64'(busy1), 64'd0);

        // start together with reset must not launch a packet
        @(posedge clk); #1;
        op = 16'h0001; start0 = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start0 = 1'b0;
        @(negedge clk);
        chk("start_in_rst_busy", 64'(busy0), 64'd0);
        chk("start_in_rst_valid", 64'(valid0), 64'd0);

        // reset while byte 20 is on the wire
        @(posedge clk); #1;
        op = 16'h0001; sha = 48'h665544332211; spa = 32'h0A00A8C0;
        tha = 48'hAABBCCDDEEFF; tpa = 32'h0100A8C0; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        @(negedge clk);
        chk("abort_byte20", 64'(dout0), 64'hDD);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_valid", 64'(valid0), 64'd0);
        chk("abort_busy", 64'(busy0), 64'd0);
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done0 || valid0) ndone++;
        end
        chk("abort_no_done", 64'(ndone), 64'd0);

        // directed packet table; vector 0 also serves as restart after abort
        for (int k = 0; k < 5; k++) begin
            run_pkt(vecs[k].sel, vecs[k].op, vecs[k].sha, vecs[k].spa, vecs[k].tha,
                    vecs[k].tpa, vecs[k].bp, -1, 1'b0);
            check_pkt(vecs[k]);
            if (k == 0) begin
                // receive-side decode of the captured stream
                if (cap.size() >= 28) begin
                    d_htype = {cap[0], cap[1]};
                    d_ptype = {cap[2], cap[3]};
                    d_hlen  = cap[4];
                    d_plen  = cap[5];
                    d_op    = {cap[6], cap[7]};
                    for (int j = 0; j < 6; j++) d_sha[8*j +: 8] = cap[8 + j];
                    for (int j = 0; j < 4; j++) d_spa[8*j +: 8] = cap[14 + j];
                    for (int j = 0; j < 6; j++) d_tha[8*j +: 8] = cap[18 + j];
                    for (int j = 0; j < 4; j++) d_tpa[8*j +: 8] = cap[24 + j];
                    d_err = (d_htype != 16'h0001) || (d_ptype != 16'h0800) ||
                            (d_hlen != 8'd6) || (d_plen != 8'd4) ||
                            (d_op != 16'h0001 && d_op != 16'h0002);
                    chk("lb_err", 64'(d_err), 64'd0);
                    chk("lb_op", 64'(d_op), 64'h0001);
                    chk("lb_sha", 64'(d_sha), 64'(vecs[0].sha));
                    chk("lb_spa", 64'(d_spa), 64'(vecs[0].spa));
                    chk("lb_tha", 64'(d_tha), 64'(vecs[0].tha));
                    chk("lb_tpa", 64'(d_tpa), 64'(vecs[0].tpa));
                end else begin
                    chk("lb_len", 64'(cap.size()), 64'd28);
                end
            end
        end

        // start at byte 10 and again on the done cycle: both ignored
        run_pkt(1'b0, 16'h0001, 48'h665544332211, 32'h0A00A8C0, 48'h0, 32'h0100A8C0,
                1'b0, 10, 1'b1);
        check_pkt('{"busy_start", 1'b0, 16'h0001, 48'h665544332211, 32'h0A00A8C0,
                    48'h0, 32'h0100A8C0, 1'b0, 1'b1, 46});
        @(negedge clk);
        chk("busy_start_idle", 64'(busy0), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
